// File: rtl/hazard_unit.sv
// Pipeline hazard detector for the 5-stage MIPS core: stall/flush/extend requests plus mult/div EX occupancy.
// Optional macro HAZARD_NO_FWD_EN: no forwarding paths, so ID also waits on any in-flight ALU producer.
module hazard_unit #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] stage_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       ex_branch_taken,
  input  logic       ex_muldiv,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic [4:0] stall,
  output logic [4:0] flush,
  output logic [4:0] extend,
  output logic       muldiv_busy,
  output logic       muldiv_done
);

  localparam int CW = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = (MULDIV_CYCLES > 1) ? CW'(MULDIV_CYCLES - 2) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic mem_wait, md_start, ext_ex, done_d;
  logic hit_ex, hazard, flush_id, stall_id;

  assign mem_wait = stage_valid[3] & mem_access & ~mem_ready;
  assign md_start = stage_valid[2] & ex_muldiv;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_ex  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          if (MULDIV_CYCLES > 1) begin
            ext_ex  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end else begin
            done_d = ~mem_wait;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          ext_ex = 1'b1;
          cnt_d  = cnt_q - CW'(1);
        end else if (!mem_wait) begin
          // Holding in BUSY under a MEM wait keeps the same instruction from re-triggering.
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hit_ex = (ex_rd != 5'd0) &
                  ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

`ifdef HAZARD_NO_FWD_EN
  logic hit_mem;
  logic unused_sv;
  assign hit_mem = (mem_rd != 5'd0) &
                   ((id_uses_rs & (id_rs == mem_rd)) | (id_uses_rt & (id_rt == mem_rd)));
  assign hazard  = (stage_valid[2] & ex_regwrite & hit_ex) |
                   (stage_valid[3] & mem_regwrite & hit_mem);
  assign unused_sv = ^{stage_valid[4], stage_valid[0], ex_memread};
`else
  logic unused_sv;
  assign hazard    = stage_valid[2] & ex_regwrite & ex_memread & hit_ex;
  assign unused_sv = ^{stage_valid[4], stage_valid[0], mem_rd, mem_regwrite};
`endif

  // A wrong-path instruction in ID is being flushed, so it must not also stall.
  assign flush_id = stage_valid[2] & ex_branch_taken & ~ext_ex & ~mem_wait;
  assign stall_id = stage_valid[1] & hazard & ~flush_id;

  always_comb begin
    stall       = 5'b0;
    flush       = 5'b0;
    extend      = 5'b0;
    muldiv_busy = 1'b0;
    muldiv_done = 1'b0;
    if (rst) begin
      stall[1]    = stall_id;
      flush[1]    = flush_id;
      extend[2]   = ext_ex;
      extend[3]   = mem_wait;
      muldiv_busy = (state_q == BUSY);
      muldiv_done = done_d;
    end
  end

endmodule
